// File: rtl/ddr_port0_writer_if.sv
// Pixel-stream and MIG port-0 write/command bus for ddr_port0_writer.
// The master modport is the writer's view and the slave modport is the engine/MIG side.
interface ddr_port0_writer_if;
  logic [31:0] pix_data;
  logic        pix_valid;
  logic        pix_ready;
  logic [31:0] wr_data;
  logic [3:0]  wr_mask;
  logic        wr_en;
  logic        wr_full;
  logic [2:0]  cmd_instr;
  logic [5:0]  cmd_bl;
  logic [29:0] cmd_byte_addr;
  logic        cmd_en;
  logic        cmd_full;

  modport master (
    input  pix_data, pix_valid, wr_full, cmd_full,
    output pix_ready, wr_data, wr_mask, wr_en, cmd_instr, cmd_bl, cmd_byte_addr, cmd_en
  );

  modport slave (
    output pix_data, pix_valid, wr_full, cmd_full,
    input  pix_ready, wr_data, wr_mask, wr_en, cmd_instr, cmd_bl, cmd_byte_addr, cmd_en
  );
endinterface

// File: rtl/ddr_port0_writer.sv
// Packs the engine's pixel stream into MIG port-0 write bursts aimed at the back buffer
// and flips base_selector once a frame is complete. Define COLOR_MAP_EN for the colour map.
module ddr_port0_writer #(
  parameter int          BURST_LEN = 64,
  parameter logic [29:0] BUF1_BASE = 30'd5242880,
  parameter int          MAX_ITER  = 255
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        mem_calib_done,
  input  logic        frame_start,
  input  logic [20:0] frame_pixels,
  ddr_port0_writer_if.master bus,
  output logic        base_selector,
  output logic        frame_done,
  output logic        busy
);

  typedef enum logic [2:0] {
    S_CAL,
    S_IDLE,
    S_FILL,
    S_SETTLE,
    S_CMD,
    S_NEXT
  } state_t;

  localparam logic [20:0] BURST_MAX = 21'(BURST_LEN);

  state_t      state;
  logic        cal_meta;
  logic        cal_sync;
  logic [20:0] frame_len;
  logic [20:0] word_idx;
  logic [20:0] burst_cnt;
  logic [20:0] fill_pos;
  logic [20:0] next_idx;
  logic [29:0] wbase;

  function automatic logic [31:0] map_pixel(input logic [31:0] c);
`ifdef COLOR_MAP_EN
    if (c == 32'(MAX_ITER))
      map_pixel = 32'h0;
    else
      map_pixel = {8'h00, c[7:0], c[6:0], 1'b0, ~c[7:0]};
`else
    map_pixel = c;
`endif
  endfunction

`ifndef COLOR_MAP_EN
  logic unused_max_iter;
  assign unused_max_iter = (MAX_ITER == 0);
`endif

  assign fill_pos = word_idx + burst_cnt;
  assign next_idx = word_idx + burst_cnt;
  assign wbase    = base_selector ? 30'd0 : BUF1_BASE;

  assign bus.wr_mask   = 4'b0000;
  assign bus.cmd_instr = 3'b000;
  assign bus.pix_ready = (state == S_FILL) && !bus.wr_full &&
                         (burst_cnt < BURST_MAX) && (fill_pos < frame_len);

  // calibration comes from the MIG's own domain, so it is double-registered first
  always_ff @(posedge clk) begin
    if (!reset) begin
      cal_meta <= 1'b0;
      cal_sync <= 1'b0;
    end else begin
      cal_meta <= mem_calib_done;
      cal_sync <= cal_meta;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state             <= S_CAL;
      frame_len         <= '0;
      word_idx          <= '0;
      burst_cnt         <= '0;
      bus.wr_en         <= 1'b0;
      bus.wr_data       <= '0;
      bus.cmd_en        <= 1'b0;
      bus.cmd_bl        <= '0;
      bus.cmd_byte_addr <= '0;
      base_selector     <= 1'b0;
      frame_done        <= 1'b0;
      busy              <= 1'b0;
    end else begin
      bus.wr_en  <= 1'b0;
      bus.cmd_en <= 1'b0;
      frame_done <= 1'b0;
      case (state)
        S_CAL: begin
          if (cal_sync) state <= S_IDLE;
        end
        S_IDLE: begin
          if (frame_start && frame_pixels != '0) begin
            frame_len <= frame_pixels;
            word_idx  <= '0;
            burst_cnt <= '0;
            busy      <= 1'b1;
            state     <= S_FILL;
          end
        end
        S_FILL: begin
          if (burst_cnt == BURST_MAX || fill_pos == frame_len) begin
            state <= S_SETTLE;
          end else if (bus.pix_valid && bus.pix_ready) begin
            bus.wr_en   <= 1'b1;
            bus.wr_data <= map_pixel(bus.pix_data);
            burst_cnt   <= burst_cnt + 21'd1;
          end
        end
        // the last data push needs a cycle to reach the FIFO before its command
        S_SETTLE: begin
          state <= S_CMD;
        end
        S_CMD: begin
          if (!bus.cmd_full) begin
            bus.cmd_en        <= 1'b1;
            bus.cmd_bl        <= 6'(burst_cnt - 21'd1);
            bus.cmd_byte_addr <= wbase + {7'd0, word_idx, 2'b00};
            state             <= S_NEXT;
          end
        end
        S_NEXT: begin
          word_idx  <= next_idx;
          burst_cnt <= '0;
          if (next_idx == frame_len) begin
            base_selector <= ~base_selector;
            frame_done    <= 1'b1;
            busy          <= 1'b0;
            state         <= S_IDLE;
          end else begin
            state <= S_FILL;
          end
        end
        default: state <= S_CAL;
      endcase
    end
  end

endmodule

// File: tb/tb_ddr_port0_writer.sv
// Randomised self-checking bench for ddr_port0_writer: a burst-splitting reference model
// predicts every command, data word and buffer flip; directed steps cover backpressure and reset.
module tb_ddr_port0_writer;

  localparam int          BL   = 64;
  localparam logic [29:0] BUF1 = 30'd5242880;

  logic        clk;
  logic        reset;
  logic        mem_calib_done;
  logic        frame_start;
  logic [20:0] frame_pixels;
  logic        base_selector;
  logic        frame_done;
  logic        busy;

  ddr_port0_writer_if bus();

  ddr_port0_writer dut (
    .clk           (clk),
    .reset         (reset),
    .mem_calib_done(mem_calib_done),
    .frame_start   (frame_start),
    .frame_pixels  (frame_pixels),
    .bus           (bus),
    .base_selector (base_selector),
    .frame_done    (frame_done),
    .busy          (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [5:0]  bl;
    logic [29:0] addr;
    int          words;
  } cmd_t;

  int          total = 0;
  int          bad = 0;
  logic [31:0] srcQ[$];
  logic [31:0] expWords[$];
  logic [31:0] wordQ[$];
  cmd_t        cmdQ[$];
  int          curN = 0;
  int          gapMode = 0;
  int          randFull = 0;
  int          forceFull = 0;
  int          holdCmd = 0;
  int          readyWhileFull = 0;
  int          cmdWhileFull = 0;
  int          readySeen = 0;
  int          wrSince = 0;
  int          doneCnt = 0;
  int          doneBase = 0;
  int          selGlitch = 0;
  logic        prevSel = 1'b0;
  logic        modelSel = 1'b0;

  function automatic logic [31:0] mapModel(input logic [31:0] c);
`ifdef COLOR_MAP_EN
    if (c == 32'd255) return 32'h0;
    return (32'(c[7:0]) << 16) | (32'((c[7:0] * 2) % 256) << 8) | 32'(8'd255 - c[7:0]);
`else
    return c;
`endif
  endfunction

  task automatic checkOutput(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    assert (got === exp) else begin
      bad++;
      $error("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // engine and MIG-FIFO side: all inputs change on the falling edge
  initial begin
    bus.pix_valid = 1'b0;
    bus.pix_data  = '0;
    bus.wr_full   = 1'b0;
    bus.cmd_full  = 1'b0;
    forever begin
      @(negedge clk);
      if (bus.cmd_en && bus.cmd_full) cmdWhileFull++;
      if (srcQ.size() > 0 && (gapMode == 0 || $urandom_range(3) != 0)) begin
        bus.pix_valid = 1'b1;
        bus.pix_data  = srcQ[0];
      end else begin
        bus.pix_valid = 1'b0;
        bus.pix_data  = $urandom();
      end
      bus.wr_full  = (forceFull > 0) || (randFull != 0 && $urandom_range(7) == 0);
      bus.cmd_full = (holdCmd > 0) || (randFull != 0 && $urandom_range(3) == 0);
      if (forceFull > 0) forceFull--;
      if (holdCmd > 0) holdCmd--;
      #1;
      if (bus.pix_ready) readySeen++;
      if (bus.pix_ready && bus.wr_full) readyWhileFull++;
      if (bus.pix_valid && bus.pix_ready) void'(srcQ.pop_front());
    end
  end

  initial begin
    forever begin
      @(negedge clk);
      if (bus.wr_en) begin
        wordQ.push_back(bus.wr_data);
        wrSince++;
      end
      if (bus.cmd_en) begin
        cmd_t c;
        c.bl    = bus.cmd_bl;
        c.addr  = bus.cmd_byte_addr;
        c.words = wrSince;
        cmdQ.push_back(c);
        wrSince = 0;
      end
      if (frame_done) doneCnt++;
      if (reset && base_selector != prevSel && !frame_done) selGlitch++;
      prevSel = base_selector;
    end
  end

  task automatic applyStimulus(input int n);
    logic [31:0] p;
    expWords.delete();
    wordQ.delete();
    cmdQ.delete();
    for (int i = 0; i < n; i++) begin
      p = (i == 0) ? 32'd255 : (i == 1) ? 32'h10 : $urandom();
      srcQ.push_back(p);
      expWords.push_back(mapModel(p));
    end
    curN = n;
    @(negedge clk);
    frame_pixels = 21'(n);
    frame_start  = 1'b1;
    doneBase     = doneCnt;
    @(negedge clk);
    frame_start  = 1'b0;
    checkOutput("busy_after_start", 64'(busy), 64'(n != 0));
  endtask

  task automatic checkFrame(input string tag);
    int budget;
    int idx;
    int k;
    int len;
    logic [29:0] wbase;
    logic [29:0] expAddr;
    budget = 0;
    while (doneCnt == doneBase && budget < 8000) begin
      @(negedge clk);
      budget++;
    end
    repeat (3) @(negedge clk);
    checkOutput({tag, "_done_pulses"}, 64'(doneCnt - doneBase), 64'd1);
    wbase = modelSel ? 30'd0 : BUF1;
    idx = 0;
    k = 0;
    while (idx < curN) begin
      len = (curN - idx < BL) ? curN - idx : BL;
      expAddr = wbase + 30'(idx * 4);
      if (k < cmdQ.size()) begin
        checkOutput({tag, "_cmd_bl"},    64'(cmdQ[k].bl),    64'(len - 1));
        checkOutput({tag, "_cmd_addr"},  64'(cmdQ[k].addr),  64'(expAddr));
        checkOutput({tag, "_cmd_words"}, 64'(cmdQ[k].words), 64'(len));
      end
      idx += len;
      k++;
    end
    checkOutput({tag, "_cmd_count"},  64'(cmdQ.size()),  64'(k));
    checkOutput({tag, "_word_count"}, 64'(wordQ.size()), 64'(expWords.size()));
    for (int i = 0; i < expWords.size() && i < wordQ.size(); i++)
      checkOutput({tag, "_word"}, 64'(wordQ[i]), 64'(expWords[i]));
    modelSel = ~modelSel;
    checkOutput({tag, "_base_selector"}, 64'(base_selector), 64'(modelSel));
    checkOutput({tag, "_busy_end"}, 64'(busy), 64'd0);
  endtask

  task automatic checkResetState(input string tag);
    checkOutput({tag, "_pix_ready"},     64'(bus.pix_ready),     64'd0);
    checkOutput({tag, "_wr_en"},         64'(bus.wr_en),         64'd0);
    checkOutput({tag, "_cmd_en"},        64'(bus.cmd_en),        64'd0);
    checkOutput({tag, "_frame_done"},    64'(frame_done),        64'd0);
    checkOutput({tag, "_busy"},          64'(busy),              64'd0);
    checkOutput({tag, "_base_selector"}, 64'(base_selector),     64'd0);
    checkOutput({tag, "_wr_data"},       64'(bus.wr_data),       64'd0);
    checkOutput({tag, "_cmd_bl"},        64'(bus.cmd_bl),        64'd0);
    checkOutput({tag, "_cmd_addr"},      64'(bus.cmd_byte_addr), 64'd0);
    checkOutput({tag, "_wr_mask"},       64'(bus.wr_mask),       64'd0);
    checkOutput({tag, "_cmd_instr"},     64'(bus.cmd_instr),     64'd0);
  endtask

  initial begin
    reset          = 1'b0;
    mem_calib_done = 1'b0;
    frame_start    = 1'b0;
    frame_pixels   = '0;
    repeat (3) @(negedge clk);
    checkResetState("reset");
    reset = 1'b1;

    // no calibration: a frame request with data waiting must be ignored
    for (int i = 0; i < 8; i++) srcQ.push_back($urandom());
    readySeen = 0;
    @(negedge clk);
    frame_pixels = 21'd130;
    frame_start  = 1'b1;
    @(negedge clk);
    frame_start  = 1'b0;
    repeat (20) @(negedge clk);
    checkOutput("nocal_ready",  64'(readySeen),    64'd0);
    checkOutput("nocal_wr_en",  64'(wordQ.size()), 64'd0);
    checkOutput("nocal_cmd_en", 64'(cmdQ.size()),  64'd0);
    checkOutput("nocal_busy",   64'(busy),         64'd0);
    srcQ.delete();

    mem_calib_done = 1'b1;
    repeat (5) @(negedge clk);

    applyStimulus(130);
    checkFrame("frame130_a");
    applyStimulus(130);
    checkFrame("frame130_b");

    applyStimulus(0);
    repeat (5) @(negedge clk);
    checkOutput("zero_cmds", 64'(cmdQ.size()), 64'd0);

    readyWhileFull = 0;
    applyStimulus(200);
    repeat (20) @(negedge clk);
    forceFull = 5;
    checkFrame("wrfull");
    checkOutput("ready_while_full", 64'(readyWhileFull), 64'd0);

    cmdWhileFull = 0;
    holdCmd = 90;
    applyStimulus(100);
    checkFrame("cmdfull");
    checkOutput("cmd_en_while_full", 64'(cmdWhileFull), 64'd0);

    applyStimulus(128);
    checkFrame("exact_multiple");
    applyStimulus(1);
    checkFrame("single_pixel");

    gapMode  = 1;
    randFull = 1;
    for (int i = 0; i < 6; i++) begin
      applyStimulus($urandom_range(300, 2));
      checkFrame("random");
    end
    checkOutput("ready_while_full_rand", 64'(readyWhileFull), 64'd0);
    checkOutput("cmd_en_while_full_rand", 64'(cmdWhileFull), 64'd0);
    gapMode  = 0;
    randFull = 0;
    repeat (4) @(negedge clk);

    // reset in the middle of a burst, with calibration lost
    applyStimulus(200);
    repeat (30) @(negedge clk);
    reset          = 1'b0;
    mem_calib_done = 1'b0;
    @(negedge clk);
    checkResetState("midreset");
    srcQ.delete();
    @(negedge clk);
    wrSince = 0;
    reset   = 1'b1;
    modelSel = 1'b0;
    @(negedge clk);
    frame_pixels = 21'd70;
    frame_start  = 1'b1;
    @(negedge clk);
    frame_start  = 1'b0;
    repeat (8) @(negedge clk);
    checkOutput("cal_reentered_busy", 64'(busy), 64'd0);
    mem_calib_done = 1'b1;
    repeat (5) @(negedge clk);
    applyStimulus(70);
    checkFrame("after_reset");

    checkOutput("selector_glitches", 64'(selGlitch), 64'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #600000;
    $display("FAIL watchdog expired total=%0d bad=%0d", total, bad);
    $fatal(1, "[TB] watchdog");
  end

endmodule
